// File: rtl/subpel_tile_scheduler.sv
// Tile sequencer for subpixel_interpolation: fetches TILE reference rows into a local
// buffer, then releases the interpolator for a fixed window and pulses done.
module subpel_tile_scheduler #(
  parameter int PIX_W         = 8,
  parameter int TILE          = 15,
  parameter int ROW_W         = TILE * PIX_W,
  parameter int ADDR_W        = 12,
  parameter int RD_LAT        = 1,
  parameter int INTERP_CYCLES = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic              abort,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [ROW_W-1:0]  mem_rd_data,
  output logic              ip_rst,
  input  logic [7:0]        ip_next_row,
  output logic [ROW_W-1:0]  ip_in_row,
  output logic              busy,
  output logic              done,
  output logic              row_err
);

  localparam int CNT_MAX = (TILE > INTERP_CYCLES) ? ((TILE > RD_LAT) ? TILE : RD_LAT)
                                                  : ((INTERP_CYCLES > RD_LAT) ? INTERP_CYCLES : RD_LAT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TAG_W   = (TILE > 1) ? $clog2(TILE) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [ADDR_W-1:0]  base;
  logic               hold;
  logic               accept;
  logic               kill;
  logic               wr_en;
  logic [RD_LAT-1:0]  tag_vld;
  logic [TAG_W-1:0]   tag_k [RD_LAT];
  logic [ROW_W-1:0]   row_buf [TILE];

  assign accept = (state == IDLE) && req_valid && !abort;
  assign kill   = abort && (state != IDLE);
  assign wr_en  = tag_vld[RD_LAT-1] && !kill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // RUN lasts INTERP_CYCLES-1 cycles; the DONE cycle completes the ip_rst=1 window.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = LOAD;
          cnt_nx   = '0;
        end
      end
      LOAD: begin
        if (cnt == CNT_W'(TILE - 1)) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(RD_LAT - 1)) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(INTERP_CYCLES - 2)) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
    if (kill) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    req_ready = (state == IDLE) && !abort;
    mem_rd_en = (state == LOAD);
    mem_addr  = (state == LOAD) ? base + ADDR_W'(cnt) : '0;
    done      = (state == DONE);
    ip_rst    = (state == RUN) || (state == DONE) || ((state == IDLE) && hold);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base    <= '0;
      hold    <= 1'b0;
      row_err <= 1'b0;
    end else begin
      if (accept) begin
        base <= req_base;
      end
      if ((state == DONE) && !abort) begin
        hold <= 1'b1;
      end else if (accept || kill) begin
        hold <= 1'b0;
      end
      if (accept) begin
        row_err <= 1'b0;
      end else if (ip_rst && (ip_next_row >= 8'(TILE))) begin
        row_err <= 1'b1;
      end
    end
  end

  // Row index travels alongside the read so capture needs no data-valid from memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_k[i] <= '0;
      end
    end else if (kill) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= (state == LOAD);
      tag_k[0]   <= TAG_W'(cnt);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_k[i]   <= tag_k[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < TILE; i++) begin
        row_buf[i] <= '0;
      end
    end else if (wr_en) begin
      row_buf[tag_k[RD_LAT-1]] <= mem_rd_data;
    end
  end

  always_comb begin
    ip_in_row = '0;
    if (ip_next_row < 8'(TILE)) begin
      ip_in_row = row_buf[ip_next_row[TAG_W-1:0]];
    end
  end

endmodule

// File: tb/tb_subpel_tile_scheduler.sv
// Bench for subpel_tile_scheduler: directed scenarios plus random traffic against a
// per-tile timeline model; a second instance exercises RD_LAT=3.
module tb_subpel_tile_scheduler;

  localparam int TILE   = 15;
  localparam int RL     = 1;
  localparam int IC     = 28;
  localparam int DONE_T = TILE + RL + IC;
  localparam int RUN_T  = TILE + RL + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, abort, mem_rd_en, ip_rst, busy, done, row_err;
  logic [11:0]  req_base, mem_addr;
  logic [119:0] mem_rd_data, ip_in_row;
  logic [7:0]   ip_next_row;

  logic         req_valid3, req_ready3, mem_rd_en3, ip_rst3, busy3, done3, row_err3;
  logic [11:0]  mem_addr3;
  logic [119:0] mem_rd_data3, ip_in_row3;
  logic [7:0]   idx3;
  logic [119:0] p3 [3];

  always #5 clk = ~clk;

  subpel_tile_scheduler u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_base(req_base),
    .abort(abort), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .ip_rst(ip_rst), .ip_next_row(ip_next_row), .ip_in_row(ip_in_row), .busy(busy),
    .done(done), .row_err(row_err)
  );

  subpel_tile_scheduler #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3), .req_base(req_base),
    .abort(1'b0), .mem_rd_en(mem_rd_en3), .mem_addr(mem_addr3), .mem_rd_data(mem_rd_data3),
    .ip_rst(ip_rst3), .ip_next_row(idx3), .ip_in_row(ip_in_row3), .busy(busy3),
    .done(done3), .row_err(row_err3)
  );

  function automatic logic [119:0] mem_row(input logic [11:0] a);
    return {10{a}};
  endfunction

  // Line memories: valid data RD_LAT cycles after the strobe, garbage otherwise.
  always @(posedge clk) begin
    mem_rd_data <= mem_rd_en ? mem_row(mem_addr) : 120'({$urandom, $urandom, $urandom, $urandom});
    p3[0] <= mem_rd_en3 ? mem_row(mem_addr3) : 120'({$urandom, $urandom, $urandom, $urandom});
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mem_rd_data3 = p3[2];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  bit           m_busy, m_hold, m_err, m_bufok;
  int           m_t, cyc, acc_cyc;
  logic [11:0]  m_base;
  logic [119:0] m_buf [TILE];

  task automatic model_reset();
    m_busy = 0; m_hold = 0; m_err = 0; m_bufok = 1; m_t = 0;
    for (int r = 0; r < TILE; r++) m_buf[r] = '0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit          e_load, e_rst, s_acc, s_bad, s_abort;
    logic [11:0] ea, s_base;
    @(negedge clk);
    e_load = m_busy && (m_t <= TILE);
    e_rst  = m_busy ? (m_t >= RUN_T) : m_hold;
    ea     = e_load ? m_base + 12'(m_t - 1) : 12'h000;
    check_eq("busy", 128'(busy), 128'(m_busy));
    check_eq("mem_rd_en", 128'(mem_rd_en), 128'(e_load));
    check_eq("mem_addr", 128'(mem_addr), 128'(ea));
    check_eq("ip_rst", 128'(ip_rst), 128'(e_rst));
    check_eq("done", 128'(done), 128'(m_busy && (m_t == DONE_T)));
    check_eq("req_ready", 128'(req_ready), 128'(!m_busy && !abort));
    check_eq("row_err", 128'(row_err), 128'(m_err));
    if (ip_next_row >= 8'(TILE))
      check_eq("in_row_oob", 128'(ip_in_row), 128'(0));
    else if (m_bufok && (!m_busy || m_t >= RUN_T))
      check_eq("in_row", 128'(ip_in_row), 128'(m_buf[ip_next_row]));
    if (done) check_eq("done_lat", 128'(cyc - acc_cyc + 1), 128'(DONE_T));
    s_acc   = !m_busy && req_valid && !abort;
    s_bad   = e_rst && (ip_next_row >= 8'(TILE));
    s_abort = abort;
    s_base  = req_base;
    @(posedge clk);
    cyc++;
    if (s_acc) m_err = 0;
    else if (s_bad) m_err = 1;
    if (m_busy) begin
      if (s_abort) begin
        m_busy = 0; m_hold = 0; m_bufok = 0;
      end else if (m_t == DONE_T) begin
        m_busy = 0; m_hold = 1;
      end else begin
        m_t++;
      end
    end else if (s_acc) begin
      m_busy = 1; m_t = 1; m_base = s_base; acc_cyc = cyc; m_bufok = 1;
      for (int r = 0; r < TILE; r++) m_buf[r] = mem_row(s_base + 12'(r));
    end
    #1;
  endtask

  task automatic one_tile(input logic [11:0] b, input logic [7:0] idx);
    req_base = b; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; ip_next_row = idx;
    repeat (DONE_T + 2) tick();
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_base = '0; abort = 1'b0; ip_next_row = '0;
    req_valid3 = 1'b0; idx3 = '0; cyc = 0; acc_cyc = 0;
    model_reset();
    #130 rst = 1'b1;
    #1;
    check_eq("rst_ip_rst", 128'(ip_rst), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_req_ready", 128'(req_ready), 128'(1));
    check_eq("rst_done", 128'(done), 128'(0));
    for (int i = 0; i < 256; i++) begin
      ip_next_row = 8'(i);
      #1 check_eq("rst_in_row", 128'(ip_in_row), 128'(0));
    end
    ip_next_row = '0;
    @(posedge clk); #1;

    one_tile(12'h010, 8'd3);
    one_tile(12'hFF8, 8'd9);

    // Abort during LOAD at k=7, then a fresh tile.
    req_base = 12'h3A0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (7) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (3) tick();
    one_tile(12'h3A0, 8'd14);

    // Back-to-back with req_valid held high.
    req_base = 12'h7F0; req_valid = 1'b1; ip_next_row = 8'd0;
    repeat (2 * (DONE_T + 1) + 3) tick();
    req_valid = 1'b0;
    repeat (3) tick();

    // Out-of-range index during RUN.
    req_base = 12'h100; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; ip_next_row = 8'd2;
    repeat (RUN_T + 3) tick();
    ip_next_row = 8'd15;
    repeat (3) tick();
    ip_next_row = 8'd2;
    repeat (DONE_T) tick();
    one_tile(12'h200, 8'd6);

    // Random traffic.
    repeat (2000) begin
      req_valid   = ($urandom_range(0, 3) == 0);
      req_base    = 12'($urandom);
      abort       = ($urandom_range(0, 99) == 0);
      ip_next_row = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(15, 255))
                                                : 8'($urandom_range(0, 14));
      tick();
    end
    abort = 1'b0; req_valid = 1'b0;
    repeat (DONE_T + 2) tick();

    // Asynchronous reset mid-LOAD; in-flight returns must not reach the buffer.
    req_base = 12'h555; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    check_eq("arst_busy", 128'(busy), 128'(0));
    check_eq("arst_ip_rst", 128'(ip_rst), 128'(0));
    check_eq("arst_rd_en", 128'(mem_rd_en), 128'(0));
    check_eq("arst_addr", 128'(mem_addr), 128'(0));
    model_reset();
    #2 rst = 1'b1;
    repeat (6) begin
      ip_next_row = 8'($urandom_range(0, 14));
      tick();
    end

    // RD_LAT=3 instance: done lands one cycle per extra latency later.
    req_base = 12'h010; req_valid3 = 1'b1; idx3 = 8'd5;
    tick();
    req_valid3 = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      check_eq("l3_rd_en", 128'(mem_rd_en3), 128'(n <= TILE));
      check_eq("l3_addr", 128'(mem_addr3), 128'((n <= TILE) ? 12'h010 + 12'(n - 1) : 12'h000));
      check_eq("l3_ip_rst", 128'(ip_rst3), 128'(n >= TILE + 3 + 1));
      check_eq("l3_done", 128'(done3), 128'(n == TILE + 3 + IC));
      if (n >= TILE + 3 + 1) check_eq("l3_in_row", 128'(ip_in_row3), 128'(mem_row(12'h015)));
      tick();
    end
    for (int r = 0; r < TILE; r++) begin
      idx3 = 8'(r);
      #1 check_eq("l3_buf", 128'(ip_in_row3), 128'(mem_row(12'h010 + 12'(r))));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
